raizing_sndcmd_tx: RTL and testbench

- Main-CPU (68000) end of the sound-command link; the sound block is the receiver.
- Queues 68k command bytes and drives them one at a time onto SOUNDLATCH.
- Raises Z80INT for each byte, then waits for the sound block's WAIT handshake to rise and fall before sending the next.
- Lives in the main-CPU board module, between the 68k bus decoder and the sound block's SOUNDLATCH/Z80INT/WAIT ports.

---
 rtl/raizing_snd_pkg.sv | 26 ++
 rtl/raizing_sndcmd_tx_if.sv | 27 ++
 rtl/raizing_sndcmd_fifo.sv | 52 +++++
 rtl/raizing_sndcmd_tx.sv | 173 +++++++++++++++++
 tb/tb_raizing_sndcmd_tx.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/raizing_snd_pkg.sv
// Shared definitions for the 68k-to-sound-CPU command link.
// Provides the transmitter FSM state encoding, the STATUS register bit
// positions and the default timing values.
package raizing_snd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACK_HI = 3'd2,
    ST_ACK_LO = 3'd3,
    ST_GAPST  = 3'd4
  } snd_state_e;

  // STATUS = {OVF, TOUT, 2'b0, FULL, EMPTY, BUSY, WAIT_SYNC}
  localparam int unsigned STAT_OVF   = 7;
  localparam int unsigned STAT_TOUT  = 6;
  localparam int unsigned STAT_FULL  = 3;
  localparam int unsigned STAT_EMPTY = 2;
  localparam int unsigned STAT_BUSY  = 1;
  localparam int unsigned STAT_WAIT  = 0;

  localparam int unsigned DEF_SETUP   = 2;
  localparam int unsigned DEF_GAP     = 4;
  localparam logic [19:0] DEF_TIMEOUT = 20'hFFFFF;

endpackage

// File: rtl/raizing_sndcmd_tx_if.sv
// Bus bundle between the 68k decoder / sound block and the command transmitter.
//   CMD_WR/CMD_DIN : 68k write strobe and command byte
//   STAT_RD/STATUS : 68k status read strobe and registered status byte
//   SOUNDLATCH     : byte presented to the sound CPU
//   Z80INT/WAIT    : request level out, receiver handshake in
//   BUSY           : FIFO non-empty or transfer in progress
// master = driver side (68k + receiver), slave = transmitter.
interface raizing_sndcmd_tx_if;
  logic       CMD_WR;
  logic [7:0] CMD_DIN;
  logic       STAT_RD;
  logic [7:0] STATUS;
  logic [7:0] SOUNDLATCH;
  logic       Z80INT;
  logic       WAIT;
  logic       BUSY;

  modport master (
    output CMD_WR, CMD_DIN, STAT_RD, WAIT,
    input  STATUS, SOUNDLATCH, Z80INT, BUSY
  );

  modport slave (
    input  CMD_WR, CMD_DIN, STAT_RD, WAIT,
    output STATUS, SOUNDLATCH, Z80INT, BUSY
  );
endinterface

// File: rtl/raizing_sndcmd_fifo.sv
// Synchronous first-word-fall-through FIFO for command bytes.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_din : write request and data
//   i_pop        : read request (head is o_dout, valid while !o_empty)
//   o_full/o_empty : pointer-derived flags
//   o_ovf        : one-cycle pulse when a push is dropped
// Push and pop in the same cycle are both honoured, even when full.
module raizing_sndcmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_ovf     = i_push && !w_do_push;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/raizing_sndcmd_tx.sv
// 68000-side transmitter of the sound-command link.
// Queues command bytes written by the 68k, presents them one at a time on
// SOUNDLATCH, raises Z80INT per byte and waits for the receiver's WAIT to
// rise and fall (each phase bounded by TIMEOUT) before a GAP of idle cycles.
//   CLK96, RESET96 : clock, synchronous active-high reset
//   bus (slave)    : CMD_WR/CMD_DIN, STAT_RD/STATUS, SOUNDLATCH, Z80INT, WAIT, BUSY
module raizing_sndcmd_tx
  import raizing_snd_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SETUP   = DEF_SETUP,
  parameter int unsigned GAP     = DEF_GAP,
  parameter logic [19:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic                CLK96,
  input  logic                RESET96,
  raizing_sndcmd_tx_if.slave  bus
);
  localparam logic [19:0] SETUP_LAST = 20'(SETUP - 1);
  localparam logic [19:0] GAP_LAST   = 20'(GAP - 1);
  localparam logic [7:0]  STATUS_RST = 8'(1 << STAT_EMPTY);

  snd_state_e  r_state;
  logic [19:0] r_cnt;
  logic [7:0]  r_latch;
  logic        r_z80int;
  logic        r_wait_meta;
  logic        r_wait_sync;
  logic        r_ovf;
  logic        r_tout;
  logic        r_busy;
  logic [7:0]  r_status;

  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_ovf_evt;
  logic        w_tout_evt;
  logic        w_ovf_nxt;
  logic        w_tout_nxt;
  logic        w_busy;
  logic [7:0]  w_head;
  logic [7:0]  w_status_nxt;

  raizing_sndcmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (CLK96),
    .i_rst   (RESET96),
    .i_push  (bus.CMD_WR),
    .i_din   (bus.CMD_DIN),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_ovf   (w_ovf_evt)
  );

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      r_wait_meta <= 1'b0;
      r_wait_sync <= 1'b0;
    end else begin
      r_wait_meta <= bus.WAIT;
      r_wait_sync <= r_wait_meta;
    end
  end

  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_tout_evt = (r_cnt == TIMEOUT) &&
                      (((r_state == ST_ACK_HI) && !r_wait_sync) ||
                       ((r_state == ST_ACK_LO) &&  r_wait_sync));
  assign w_busy     = !w_empty || (r_state != ST_IDLE);

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_latch  <= '0;
      r_z80int <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_latch <= w_head;
            r_cnt   <= '0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_z80int <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_ACK_HI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ACK_HI: begin
          // An already-high WAIT_SYNC is accepted on entry.
          if (r_wait_sync) begin
            r_cnt   <= '0;
            r_state <= ST_ACK_LO;
          end else if (r_cnt == TIMEOUT) begin
            r_z80int <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_GAPST;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ACK_LO: begin
          if (!r_wait_sync || (r_cnt == TIMEOUT)) begin
            r_z80int <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_GAPST;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAPST: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_z80int <= 1'b0;
          r_cnt    <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Set wins over a simultaneous status-read clear.
  assign w_ovf_nxt  = w_ovf_evt  || (r_ovf  && !bus.STAT_RD);
  assign w_tout_nxt = w_tout_evt || (r_tout && !bus.STAT_RD);

  always_comb begin
    w_status_nxt             = '0;
    w_status_nxt[STAT_OVF]   = w_ovf_nxt;
    w_status_nxt[STAT_TOUT]  = w_tout_nxt;
    w_status_nxt[STAT_FULL]  = w_full;
    w_status_nxt[STAT_EMPTY] = w_empty;
    w_status_nxt[STAT_BUSY]  = w_busy;
    w_status_nxt[STAT_WAIT]  = r_wait_sync;
  end

  // Sticky bits are registered from their next value so a read clears
  // them in STATUS on the cycle right after the read.
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      r_ovf    <= 1'b0;
      r_tout   <= 1'b0;
      r_busy   <= 1'b0;
      r_status <= STATUS_RST;
    end else begin
      r_ovf    <= w_ovf_nxt;
      r_tout   <= w_tout_nxt;
      r_busy   <= w_busy;
      r_status <= w_status_nxt;
    end
  end

  assign bus.SOUNDLATCH = r_latch;
  assign bus.Z80INT     = r_z80int;
  assign bus.BUSY       = r_busy;
  assign bus.STATUS     = r_status;
endmodule

// File: tb/tb_raizing_sndcmd_tx.sv
// Directed bench for raizing_sndcmd_tx (DEPTH=4, SETUP=2, GAP=4, TIMEOUT=32).
// A background receiver answers each Z80INT edge (WAIT high 3 cycles after,
// low 10 cycles later) unless rx_never is set; a monitor logs every Z80INT
// rising edge with the SOUNDLATCH value and cycle number.
module tb_raizing_sndcmd_tx;
  logic clk = 1'b0;
  logic RESET96;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   rx_never = 1'b0;

  logic [7:0] q_lat[$];
  logic [7:0] q_pre[$];
  int         q_cyc[$];
  logic       z_prev = 1'b0;
  logic [7:0] latch_prev = 8'h00;

  raizing_sndcmd_tx_if bus ();

  raizing_sndcmd_tx #(
    .DEPTH   (4),
    .SETUP   (2),
    .GAP     (4),
    .TIMEOUT (20'd32)
  ) dut (
    .CLK96   (clk),
    .RESET96 (RESET96),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.Z80INT === 1'b1 && z_prev !== 1'b1) begin
      q_lat.push_back(bus.SOUNDLATCH);
      q_pre.push_back(latch_prev);
      q_cyc.push_back(cyc);
    end
    z_prev     = bus.Z80INT;
    latch_prev = bus.SOUNDLATCH;
  end

  initial begin
    bus.WAIT = 1'b0;
    forever begin
      @(posedge bus.Z80INT);
      if (!rx_never) begin
        repeat (3) @(posedge clk);
        #1 bus.WAIT = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.WAIT = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_log;
    q_lat.delete();
    q_pre.delete();
    q_cyc.delete();
  endtask

  task automatic apply_reset;
    @(posedge clk); #1 RESET96 = 1'b1;
    repeat (2) @(posedge clk);
    #1 RESET96 = 1'b0;
    clear_log();
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic send(input logic [7:0] b);
    bus.CMD_WR  = 1'b1;
    bus.CMD_DIN = b;
    @(posedge clk); #1;
    bus.CMD_WR  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.BUSY === 1'b0 && bus.Z80INT === 1'b0 && bus.WAIT === 1'b0) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.SOUNDLATCH !== 8'h00) begin n_fail++; $display("FAIL rst_latch: got %h want 00", bus.SOUNDLATCH); end
    n_tests++; if (bus.Z80INT !== 1'b0) begin n_fail++; $display("FAIL rst_z80int: got %b want 0", bus.Z80INT); end
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.BUSY); end
    n_tests++; if (bus.STATUS !== 8'h04) begin n_fail++; $display("FAIL rst_status: got %h want 04", bus.STATUS); end
    @(posedge clk); #1 RESET96 = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.STATUS !== 8'h04) begin n_fail++; $display("FAIL rst_status_after: got %h want 04", bus.STATUS); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int wr_cyc;
    bit ok;
    apply_reset();
    wr_cyc = cyc;
    send(8'h5A);
    @(negedge clk);
    n_tests++; if (bus.SOUNDLATCH !== 8'h00) begin n_fail++; $display("FAIL single_latch_early: got %h want 00", bus.SOUNDLATCH); end
    @(negedge clk);
    n_tests++; if (bus.SOUNDLATCH !== 8'h5A) begin n_fail++; $display("FAIL single_latch_pop: got %h want 5a", bus.SOUNDLATCH); end
    n_tests++; if (bus.Z80INT !== 1'b0) begin n_fail++; $display("FAIL single_int_early: got %b want 0", bus.Z80INT); end
    wait_idle(300, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_idle_timeout: got %b want 1", ok); end
    n_tests++; if (q_lat.size() !== 1) begin n_fail++; $display("FAIL single_edges: got %0d want 1", q_lat.size()); end
    if (q_lat.size() >= 1) begin
      n_tests++; if (q_lat[0] !== 8'h5A) begin n_fail++; $display("FAIL single_edge_latch: got %h want 5a", q_lat[0]); end
      n_tests++; if (q_pre[0] !== 8'h5A) begin n_fail++; $display("FAIL single_latch_before_int: got %h want 5a", q_pre[0]); end
      n_tests++; if (q_cyc[0] - wr_cyc !== 4) begin n_fail++; $display("FAIL single_int_latency: got %0d want 4", q_cyc[0] - wr_cyc); end
    end
    @(negedge clk);
    n_tests++; if (bus.Z80INT !== 1'b0) begin n_fail++; $display("FAIL single_int_low: got %b want 0", bus.Z80INT); end
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", bus.BUSY); end
    n_tests++; if (bus.SOUNDLATCH !== 8'h5A) begin n_fail++; $display("FAIL single_latch_hold: got %h want 5a", bus.SOUNDLATCH); end
    @(posedge clk); #1;
  endtask

  task automatic test_burst;
    bit ok;
    logic [7:0] exp_b;
    apply_reset();
    for (int i = 1; i <= 4; i++) send(8'(i));
    wait_idle(600, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL burst_idle_timeout: got %b want 1", ok); end
    n_tests++; if (q_lat.size() !== 4) begin n_fail++; $display("FAIL burst_edges: got %0d want 4", q_lat.size()); end
    for (int i = 0; i < q_lat.size() && i < 4; i++) begin
      exp_b = 8'(i + 1);
      n_tests++; if (q_lat[i] !== exp_b) begin n_fail++; $display("FAIL burst_order[%0d]: got %h want %h", i, q_lat[i], exp_b); end
      if (i > 0) begin
        n_tests++; if (q_cyc[i] - q_cyc[i-1] < 6) begin n_fail++; $display("FAIL burst_spacing[%0d]: got %0d want >=6", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
    @(negedge clk);
    n_tests++; if (bus.STATUS[7] !== 1'b0) begin n_fail++; $display("FAIL burst_no_ovf: got %b want 0", bus.STATUS[7]); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    bit ok;
    logic [7:0] exp_b;
    apply_reset();
    for (int i = 0; i < 6; i++) send(8'h11 + 8'(i));
    @(negedge clk);
    n_tests++; if (bus.STATUS[7] !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", bus.STATUS[7]); end
    wait_idle(1000, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_idle_timeout: got %b want 1", ok); end
    n_tests++; if (q_lat.size() !== 5) begin n_fail++; $display("FAIL ovf_edges: got %0d want 5", q_lat.size()); end
    for (int i = 0; i < q_lat.size() && i < 5; i++) begin
      exp_b = 8'h11 + 8'(i);
      n_tests++; if (q_lat[i] !== exp_b) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h want %h", i, q_lat[i], exp_b); end
    end
    bus.STAT_RD = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.STATUS !== 8'h84) begin n_fail++; $display("FAIL ovf_stat_read: got %h want 84", bus.STATUS); end
    @(posedge clk); #1 bus.STAT_RD = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.STATUS !== 8'h04) begin n_fail++; $display("FAIL ovf_cleared: got %h want 04", bus.STATUS); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    bit ok;
    bit found;
    int dt;
    apply_reset();
    rx_never = 1'b1;
    send(8'hA1);
    send(8'hA2);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.STATUS[6] === 1'b1) found = 1'b1;
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL tout_seen: got %b want 1", found); end
    if (found && q_cyc.size() >= 1) begin
      dt = cyc - q_cyc[0];
      n_tests++; if (dt < 32 || dt > 34) begin n_fail++; $display("FAIL tout_delay: got %0d want 32..34", dt); end
      n_tests++; if (bus.Z80INT !== 1'b0) begin n_fail++; $display("FAIL tout_int_low: got %b want 0", bus.Z80INT); end
    end
    wait_idle(300, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tout_idle_timeout: got %b want 1", ok); end
    n_tests++; if (q_lat.size() !== 2) begin n_fail++; $display("FAIL tout_edges: got %0d want 2", q_lat.size()); end
    if (q_lat.size() >= 2) begin
      n_tests++; if (q_lat[1] !== 8'hA2) begin n_fail++; $display("FAIL tout_next_byte: got %h want a2", q_lat[1]); end
    end
    rx_never = 1'b0;
  endtask

  task automatic test_full_pushpop;
    bit ok;
    bit seen_hi;
    bit fell;
    logic [7:0] exp_b;
    apply_reset();
    for (int i = 0; i < 5; i++) send(8'hB0 + 8'(i));
    seen_hi = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 100 && !fell; i++) begin
      @(negedge clk);
      if (bus.Z80INT === 1'b1) seen_hi = 1'b1;
      else if (seen_hi) fell = 1'b1;
    end
    n_tests++; if (fell !== 1'b1) begin n_fail++; $display("FAIL full_first_fall: got %b want 1", fell); end
    n_tests++; if (bus.STATUS[3] !== 1'b1) begin n_fail++; $display("FAIL full_before: got %b want 1", bus.STATUS[3]); end
    // The FSM re-enters IDLE GAP cycles after the fall and pops on the next edge.
    repeat (4) @(posedge clk);
    #1 bus.CMD_WR = 1'b1; bus.CMD_DIN = 8'hB5;
    @(posedge clk); #1 bus.CMD_WR = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.STATUS[7] !== 1'b0) begin n_fail++; $display("FAIL full_pp_no_ovf: got %b want 0", bus.STATUS[7]); end
    @(negedge clk);
    n_tests++; if (bus.STATUS[3] !== 1'b1) begin n_fail++; $display("FAIL full_pp_still_full: got %b want 1", bus.STATUS[3]); end
    @(posedge clk); #1;
    wait_idle(1000, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_idle_timeout: got %b want 1", ok); end
    n_tests++; if (q_lat.size() !== 6) begin n_fail++; $display("FAIL full_edges: got %0d want 6", q_lat.size()); end
    for (int i = 0; i < q_lat.size() && i < 6; i++) begin
      exp_b = 8'hB0 + 8'(i);
      n_tests++; if (q_lat[i] !== exp_b) begin n_fail++; $display("FAIL full_order[%0d]: got %h want %h", i, q_lat[i], exp_b); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit found;
    apply_reset();
    send(8'hC1);
    send(8'hC2);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.STATUS[0] === 1'b1) found = 1'b1;
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_ack_lo: got %b want 1", found); end
    n_tests++; if (bus.Z80INT !== 1'b1) begin n_fail++; $display("FAIL mid_int_high: got %b want 1", bus.Z80INT); end
    @(posedge clk); #1 RESET96 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.Z80INT !== 1'b0) begin n_fail++; $display("FAIL mid_int: got %b want 0", bus.Z80INT); end
    n_tests++; if (bus.SOUNDLATCH !== 8'h00) begin n_fail++; $display("FAIL mid_latch: got %h want 00", bus.SOUNDLATCH); end
    n_tests++; if (bus.STATUS !== 8'h04) begin n_fail++; $display("FAIL mid_status: got %h want 04", bus.STATUS); end
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus.BUSY); end
    @(posedge clk); #1 RESET96 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.WAIT === 1'b0) found = 1'b1;
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_wait_drop: got %b want 1", found); end
    repeat (4) @(posedge clk);
    #1 clear_log();
    send(8'hD7);
    wait_idle(300, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_idle_timeout: got %b want 1", ok); end
    n_tests++; if (q_lat.size() !== 1) begin n_fail++; $display("FAIL mid_edges: got %0d want 1", q_lat.size()); end
    if (q_lat.size() >= 1) begin
      n_tests++; if (q_lat[0] !== 8'hD7) begin n_fail++; $display("FAIL mid_next_byte: got %h want d7", q_lat[0]); end
    end
    @(negedge clk);
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_final_busy: got %b want 0", bus.BUSY); end
  endtask

  initial begin
    RESET96     = 1'b1;
    bus.CMD_WR  = 1'b0;
    bus.CMD_DIN = 8'h00;
    bus.STAT_RD = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_full_pushpop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
